// File: rtl/cpu_pkg.sv
// Shared definitions for the LDM/STM sequencer: register-bank geometry,
// default transfer stride and the sequencer state encoding.
package cpu_pkg;
  localparam int REG_IDX_W     = 4;
  localparam int NUM_REGS      = 16;
  localparam int DEF_ADDR_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;
endpackage

// File: rtl/lowest_set_bit.sv
// 16-bit priority encoder: index of the lowest set bit plus a valid flag.
module lowest_set_bit
  import cpu_pkg::*;
(
  input  logic [NUM_REGS-1:0]  vec,
  output logic [REG_IDX_W-1:0] idx,
  output logic                 valid
);

  // Scan high to low so the lowest set bit is the last one to win.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = REG_IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer. Walks the latched register list from
// the lowest to the highest index, one memory handshake per register.
// Optional base-register writeback state: define LDM_STM_WRITEBACK_EN.
module ldm_stm_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = DEF_ADDR_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        base_reg,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_src,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [3:0]        rf_dest,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  seq_state_t              state;
  logic [NUM_REGS-1:0]     pending;
  logic [NUM_REGS-1:0]     pending_nxt;
  logic [ADDR_W-1:0]       addr;
  logic                    dir;
  logic [REG_IDX_W-1:0]    idx;
  logic                    idx_vld;
  logic                    xfer;

`ifdef LDM_STM_WRITEBACK_EN
  localparam seq_state_t ST_LAST = ST_WB;
  logic [ADDR_W-1:0]       base_q;
  logic [REG_IDX_W-1:0]    base_reg_q;
  logic [4:0]              count;
`else
  localparam seq_state_t ST_LAST = ST_DONE;
  logic                    unused_base_reg;
  assign unused_base_reg = ^base_reg;
`endif

  lowest_set_bit u_lsb (
    .vec   (pending),
    .idx   (idx),
    .valid (idx_vld)
  );

  assign xfer        = (state == ST_XFER) && idx_vld;
  assign pending_nxt = pending & ~(NUM_REGS'(1) << idx);

  // Command latch and state walk; one register retired per mem_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= '0;
      addr    <= '0;
      dir     <= 1'b0;
`ifdef LDM_STM_WRITEBACK_EN
      base_q     <= '0;
      base_reg_q <= '0;
      count      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pending <= reg_list;
            addr    <= base_addr;
            dir     <= is_load;
`ifdef LDM_STM_WRITEBACK_EN
            base_q     <= base_addr;
            base_reg_q <= base_reg;
            count      <= '0;
`endif
            state <= (reg_list != '0) ? ST_XFER : ST_LAST;
          end
        end
        ST_XFER: begin
          if (mem_ack) begin
            pending <= pending_nxt;
            addr    <= addr + ADDR_W'(ADDR_STEP);
`ifdef LDM_STM_WRITEBACK_EN
            count   <= count + 5'd1;
`endif
            if (pending_nxt == '0) state <= ST_LAST;
          end
        end
`ifdef LDM_STM_WRITEBACK_EN
        ST_WB:   state <= ST_DONE;
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath outputs decoded from the registered state; the load write
  // strobe follows mem_ack in the same cycle.
  always_comb begin
    busy      = (state == ST_XFER) || (state == ST_WB);
    done      = (state == ST_DONE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_src    = '0;
    rf_dest   = '0;
    rf_wdata  = '0;
    rf_we     = 1'b0;
    if (xfer) begin
      mem_req   = 1'b1;
      mem_we    = ~dir;
      mem_addr  = addr;
      rf_src    = idx;
      mem_wdata = rf_rdata;
      if (mem_ack && dir) begin
        rf_we    = 1'b1;
        rf_dest  = idx;
        rf_wdata = mem_rdata;
      end
    end
`ifdef LDM_STM_WRITEBACK_EN
    if (state == ST_WB) begin
      rf_we    = 1'b1;
      rf_dest  = base_reg_q;
      rf_wdata = DATA_W'(base_q + ADDR_W'(ADDR_STEP) * ADDR_W'(count));
    end
`endif
  end

endmodule
